cpu_io_bridge: RTL and testbench
================================

CPU_IO_BRIDGE -- requirements
Module: cpu_io_bridge

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops on each raw strobe.
REQ-002 SHALL have parameter FILTER_LEN, default 3: consecutive equal synchronized samples needed to change a filtered strobe.
REQ-003 SHALL have parameter READ_LAT, default 2: clk_w cycles from req to sampling dbi on reads.
REQ-004 SHALL have port clk_w, input, 1 bit: 27 MHz VDP pixel/CPU clock; all state is on its rising edge.
REQ-005 SHALL have port reset_n_w, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port csr_n, input, 1 bit: raw decoded read strobe (ports $98-$9B), asynchronous to clk_w.
REQ-007 SHALL have port csw_n, input, 1 bit: raw decoded write strobe, asynchronous to clk_w.
REQ-008 SHALL have port port_sel, input, 2 bits: raw mode pins (A1:A0 port select).
REQ-009 SHALL have port cd_in, input, 8 bits: CPU data bus as seen by the FPGA.
REQ-010 SHALL have port req, output, 1 bit: one-cycle VDP access request.
REQ-011 SHALL have port wrt, output, 1 bit: 1 = write; valid only while req=1, else 0.
REQ-012 SHALL have port adr, output, 2 bits: VDP port number, held from capture until next capture.
REQ-013 SHALL have port dbo, output, 8 bits: write data to VDP, held from capture until next capture.
REQ-014 SHALL have port dbi, input, 8 bits: VDP read data.
REQ-015 SHALL have port rd_data, output, 8 bits: latched read data for the cd tri-state driver.
REQ-016 SHALL have port rd_valid, output, 1 bit: rd_data holds data for the current read cycle.
REQ-017 SHALL have port err, output, 1 bit: one-cycle pulse on an illegal strobe combination.

Function
REQ-018 SHALL pass csr_n and csw_n each through a SYNC_STAGES flop chain reset to 1.
REQ-019 SHALL produce filtered rf_n/wf_n, reset 1, that change only after FILTER_LEN consecutive synchronized samples differ from the current filtered value; shorter pulses are discarded.
REQ-020 SHALL implement FSM IDLE, ISSUE, RD_WAIT, HOLD, ERROR; reset state IDLE.
REQ-021 IDLE: rf_n=0,wf_n=1 -> ISSUE(read); wf_n=0,rf_n=1 -> ISSUE(write); both 0 -> ERROR; else stay.
REQ-022 On the IDLE->ISSUE transition SHALL capture adr<=port_sel and, for writes only, dbo<=cd_in.
REQ-023 ISSUE SHALL last exactly one cycle with req=1 and wrt=1 for a write, 0 for a read; write -> HOLD, read -> RD_WAIT.
REQ-024 RD_WAIT SHALL count READ_LAT cycles, then load rd_data<=dbi, set rd_valid=1, go to HOLD.
REQ-025 HOLD SHALL issue no further req; rf_n=1 and wf_n=1 -> IDLE and clear rd_valid.
REQ-026 ERROR SHALL pulse err for one cycle on entry, issue no req, and return to IDLE only when rf_n=1 and wf_n=1.
REQ-027 A strobe ending in RD_WAIT SHALL still complete the rd_data load, then go HOLD->IDLE on the next cycle.
REQ-028 At most one req SHALL be issued per filtered strobe assertion, however long the strobe is held.
REQ-029 Raw low to req SHALL take SYNC_STAGES+FILTER_LEN cycles (5 at defaults), from the first clk_w edge sampling the raw strobe low.

Reset
REQ-030 While reset_n_w=0: req=0, wrt=0, err=0, rd_valid=0, adr=0, dbo=0x00, rd_data=0x00, all sync/filter flops 1, filter counters 0, state IDLE.
REQ-031 Reset mid-access SHALL abort it without issuing req after release; a strobe still low at release SHALL be treated as a new access once filtered.

Verification
REQ-032 Write: csw_n low 20 cycles, port_sel=0, cd_in=0x5A -> one req, wrt=1, adr=0, dbo=0x5A, 5 cycles after the strobe falls.
REQ-033 Read: csr_n low 20 cycles, port_sel=1, dbi=0xC3 -> one req, wrt=0, adr=1; rd_data=0xC3, rd_valid=1 exactly 2 cycles after req; rd_valid=0 once the filtered strobe rises.
REQ-034 Glitch: csw_n low 2 cycles -> no req, state stays IDLE.
REQ-035 Illegal: csr_n and csw_n low together -> err one pulse, no req; next legal write -> normal req.
REQ-036 Back-to-back: two writes 0x11/0x22 separated by 4 high cycles -> exactly two reqs with dbo 0x11 then 0x22.
REQ-037 Reset mid-read: assert reset_n_w in RD_WAIT -> all outputs at reset values, no req after release while csr_n held high.

Source files
------------

// File: rtl/cpu_io_bridge.sv
// cpu_io_bridge
//   Bridges the CPU's raw, asynchronous VDP port strobes into single-cycle
//   access requests on clk_w. Each strobe is synchronized and deglitched.
//   An FSM then issues exactly one req per filtered strobe assertion. For
//   reads, it also latches the VDP read data for the CPU data-bus driver.
// Ports
//   clk_w, reset_n_w    : clock, async active-low reset
//   csr_n, csw_n        : raw read / write strobes (async)
//   port_sel, cd_in     : raw port select and CPU write data
//   req, wrt, adr, dbo  : VDP access request, direction, port, write data
//   dbi                 : VDP read data
//   rd_data, rd_valid   : latched read data and its valid flag
//   err                 : one-cycle pulse when both strobes assert together
module cpu_io_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int READ_LAT    = 2
) (
  input  logic       clk_w,
  input  logic       reset_n_w,
  input  logic       csr_n,
  input  logic       csw_n,
  input  logic [1:0] port_sel,
  input  logic [7:0] cd_in,
  output logic       req,
  output logic       wrt,
  output logic [1:0] adr,
  output logic [7:0] dbo,
  input  logic [7:0] dbi,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       err
);

  localparam int FCW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
  localparam int LCW = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, RD_WAIT, HOLD, ERROR} state_t;

  // Strobe lanes: [0] = read, [1] = write
  logic [1:0] w_raw_n;
  logic [1:0] w_filt_n;
  assign w_raw_n = {csw_n, csr_n};

  for (genvar g = 0; g < 2; g++) begin : g_strb
    logic [SYNC_STAGES-1:0] r_sync;
    logic [FCW-1:0]         r_cnt;
    logic                   r_filt;

    always_ff @(posedge clk_w or negedge reset_n_w) begin
      if (!reset_n_w) begin
        r_sync <= '1;
        r_cnt  <= '0;
        r_filt <= 1'b1;
      end else begin
        r_sync[0] <= w_raw_n[g];
        for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        // Count consecutive samples disagreeing with the filtered level.
        // Any agreeing sample restarts the run, so short pulses are dropped.
        if (r_sync[SYNC_STAGES-1] != r_filt) begin
          if (r_cnt == FCW'(FILTER_LEN - 1)) begin
            r_filt <= r_sync[SYNC_STAGES-1];
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + FCW'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end

    assign w_filt_n[g] = r_filt;
  end

  logic w_rf_n, w_wf_n;
  assign w_rf_n = w_filt_n[0];
  assign w_wf_n = w_filt_n[1];

  state_t         r_state;
  logic [LCW-1:0] r_lat;
  logic           r_req, r_wrt, r_err, r_rd_valid;
  logic [1:0]     r_adr;
  logic [7:0]     r_dbo, r_rd_data;

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      r_state    <= IDLE;
      r_lat      <= '0;
      r_req      <= 1'b0;
      r_wrt      <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_adr      <= 2'd0;
      r_dbo      <= 8'h00;
      r_rd_data  <= 8'h00;
    end else begin
      r_req <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rf_n && w_wf_n) begin
            r_state <= ISSUE;
            r_req   <= 1'b1;
            r_wrt   <= 1'b0;
            r_adr   <= port_sel;
          end else if (w_rf_n && !w_wf_n) begin
            r_state <= ISSUE;
            r_req   <= 1'b1;
            r_wrt   <= 1'b1;
            r_adr   <= port_sel;
            r_dbo   <= cd_in;
          end else if (!w_rf_n && !w_wf_n) begin
            r_state <= ERROR;
            r_err   <= 1'b1;
          end
        end
        ISSUE: begin
          // wrt only qualifies req, so it drops with it; it still tells us
          // the direction of the access this cycle.
          r_wrt <= 1'b0;
          if (r_wrt) begin
            r_state <= HOLD;
          end else if (READ_LAT <= 1) begin
            r_rd_data  <= dbi;
            r_rd_valid <= 1'b1;
            r_state    <= HOLD;
          end else begin
            r_lat   <= LCW'(1);  // the ISSUE cycle is the first latency cycle
            r_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Runs to completion even if the strobe has already ended.
          if (r_lat >= LCW'(READ_LAT - 1)) begin
            r_rd_data  <= dbi;
            r_rd_valid <= 1'b1;
            r_state    <= HOLD;
          end else begin
            r_lat <= r_lat + LCW'(1);
          end
        end
        HOLD: begin
          if (w_rf_n && w_wf_n) begin
            r_rd_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        ERROR: begin
          if (w_rf_n && w_wf_n) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req      = r_req;
  assign wrt      = r_wrt;
  assign err      = r_err;
  assign adr      = r_adr;
  assign dbo      = r_dbo;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Scoreboard bench for cpu_io_bridge. Each issued strobe pushes the events
// it should cause (req, rd_valid window, err) with their absolute cycle
// numbers into queues. A negedge monitor pops and compares them as the DUT
// produces outputs.
module tb_cpu_io_bridge;
  localparam int S  = 2;
  localparam int F  = 3;
  localparam int RL = 2;

  logic       clk_w = 1'b0;
  logic       reset_n_w = 1'b0;
  logic       csr_n = 1'b1, csw_n = 1'b1;
  logic [1:0] port_sel = 2'd0;
  logic [7:0] cd_in = 8'h00, dbi = 8'h00;
  logic       req, wrt, rd_valid, err;
  logic [1:0] adr;
  logic [7:0] dbo, rd_data;

  cpu_io_bridge #(.SYNC_STAGES(S), .FILTER_LEN(F), .READ_LAT(RL)) dut (
    .clk_w(clk_w), .reset_n_w(reset_n_w), .csr_n(csr_n), .csw_n(csw_n),
    .port_sel(port_sel), .cd_in(cd_in), .req(req), .wrt(wrt), .adr(adr),
    .dbo(dbo), .dbi(dbi), .rd_data(rd_data), .rd_valid(rd_valid), .err(err)
  );

  always #18.5 clk_w = ~clk_w;

  typedef struct { int cyc; logic wr; logic [1:0] a; logic [7:0] d; } req_t;
  typedef struct { int rise; int fall; logic [7:0] d; } rdv_t;

  req_t q_req[$];
  rdv_t q_rdv[$];
  int   q_err[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int n_req = 0;

  always @(posedge clk_w) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  req_t m_r;
  rdv_t m_v;
  int   m_e;
  logic rdv_prev = 1'b0;
  int   exp_fall = -1;

  always @(negedge clk_w) begin
    if (!reset_n_w) begin
      rdv_prev = 1'b0;
      exp_fall = -1;
    end else begin
      if (req) begin
        n_req++;
        checks++;
        if (q_req.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req cyc=%0d wrt=%0b adr=%0d", cyc, wrt, adr);
        end else begin
          m_r = q_req.pop_front();
          if (cyc != m_r.cyc || wrt != m_r.wr || adr != m_r.a || (m_r.wr && dbo != m_r.d)) begin
            errors++;
            $display("FAIL req got cyc=%0d wrt=%0b adr=%0d dbo=%02h exp cyc=%0d wrt=%0b adr=%0d dbo=%02h",
                     cyc, wrt, adr, dbo, m_r.cyc, m_r.wr, m_r.a, m_r.d);
          end
        end
      end else begin
        checks++;
        if (wrt) begin
          errors++;
          $display("FAIL wrt_without_req cyc=%0d got 1 exp 0", cyc);
        end
      end
      if (err) begin
        checks++;
        if (q_err.size() == 0) begin
          errors++;
          $display("FAIL unexpected_err cyc=%0d", cyc);
        end else begin
          m_e = q_err.pop_front();
          if (cyc != m_e) begin
            errors++;
            $display("FAIL err_cycle got %0d exp %0d", cyc, m_e);
          end
        end
      end
      if (rd_valid && !rdv_prev) begin
        checks++;
        if (q_rdv.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rd_valid cyc=%0d", cyc);
        end else begin
          m_v = q_rdv.pop_front();
          exp_fall = m_v.fall;
          if (cyc != m_v.rise || rd_data != m_v.d) begin
            errors++;
            $display("FAIL rd_valid_rise got cyc=%0d data=%02h exp cyc=%0d data=%02h",
                     cyc, rd_data, m_v.rise, m_v.d);
          end
        end
      end
      if (!rd_valid && rdv_prev) begin
        checks++;
        if (cyc != exp_fall) begin
          errors++;
          $display("FAIL rd_valid_fall got cyc=%0d exp %0d", cyc, exp_fall);
        end
      end
      rdv_prev = rd_valid;
    end
  end

  // ---------------- reference model + stimulus ----------------
  // kind: 0 write, 1 read, 2 both strobes (illegal)
  task automatic access(input int kind, input int len, input logic [1:0] ps, input logic [7:0] d);
    int t0, treq;
    req_t r;
    rdv_t v;
    @(negedge clk_w);
    port_sel = ps;
    if (kind == 0) cd_in = d;
    if (kind == 1) dbi = d;
    if (kind != 1) csw_n = 1'b0;
    if (kind != 0) csr_n = 1'b0;
    t0   = cyc + 1;     // first edge that samples the strobe low
    treq = t0 + S + F;
    if (len >= F) begin
      if (kind == 2) q_err.push_back(treq);
      else begin
        r.cyc = treq; r.wr = (kind == 0); r.a = ps; r.d = d;
        q_req.push_back(r);
      end
      if (kind == 1) begin
        v.rise = treq + RL;
        v.fall = (t0 + len + S + F > v.rise + 1) ? t0 + len + S + F : v.rise + 1;
        v.d    = d;
        q_rdv.push_back(v);
      end
    end
    repeat (len) @(negedge clk_w);
    csr_n = 1'b1;
    csw_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_w);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %02h exp %02h", name, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {7'd0, req}, 8'h00);
    chk({tag, "_wrt"}, {7'd0, wrt}, 8'h00);
    chk({tag, "_err"}, {7'd0, err}, 8'h00);
    chk({tag, "_rd_valid"}, {7'd0, rd_valid}, 8'h00);
    chk({tag, "_adr"}, {6'd0, adr}, 8'h00);
    chk({tag, "_dbo"}, dbo, 8'h00);
    chk({tag, "_rd_data"}, rd_data, 8'h00);
  endtask

  initial begin
    int t0, base;
    int kind, len;
    idle(3);
    #1 chk_reset_outputs("reset");
    @(negedge clk_w);
    reset_n_w = 1'b1;
    idle(4);

    // directed: write, read, glitch, illegal + write, back-to-back
    access(0, 20, 2'd0, 8'h5A);  idle(10);
    access(1, 20, 2'd1, 8'hC3);  idle(10);
    access(0, 2, 2'd2, 8'hEE);   idle(10);
    access(2, 10, 2'd3, 8'h00);  idle(10);
    access(0, 12, 2'd3, 8'h77);  idle(10);
    access(0, 20, 2'd2, 8'h11);  idle(4);
    access(0, 20, 2'd2, 8'h22);  idle(12);
    access(1, 3, 2'd2, 8'h9F);   idle(12);  // strobe ends before data load

    // randomized
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      kind = (kind < 4) ? 0 : (kind < 8) ? 1 : 2;
      len  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, F - 1) : $urandom_range(F, 25);
      access(kind, len, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      idle($urandom_range(6, 12));
    end

    // reset while in RD_WAIT
    @(negedge clk_w);
    port_sel = 2'd1; dbi = 8'hA5; csr_n = 1'b0;
    t0 = cyc + 1;
    begin
      req_t r;
      r.cyc = t0 + S + F; r.wr = 1'b0; r.a = 2'd1; r.d = 8'h00;
      q_req.push_back(r);
    end
    while (cyc < t0 + S + F + 1) @(negedge clk_w);
    reset_n_w = 1'b0;
    #1 chk_reset_outputs("midrd");
    @(negedge clk_w);
    csr_n = 1'b1;
    @(negedge clk_w);
    reset_n_w = 1'b1;
    base = n_req;
    idle(20);
    chk("midrd_no_req", 8'(n_req - base), 8'h00);

    idle(5);
    chk("left_req", 8'(q_req.size()), 8'h00);
    chk("left_rdv", 8'(q_rdv.size()), 8'h00);
    chk("left_err", 8'(q_err.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
